// File: rtl/sqmidi_pkg.sv
// Shared types and constants for the MIDI event sequencer.
// Contents: note number type, MIDI status/velocity constants, the
// sequencer FSM state encoding and the packed {on, note} candidate.
package sqmidi_pkg;

  typedef logic [6:0] midi_note_t;

  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [6:0] MIDI_OFF_VEL  = 7'h40;

  typedef enum logic [2:0] {
    IDLE,
    OFF0,
    OFF1,
    OFF2,
    ON0,
    ON1,
    ON2
  } seq_state_t;

  typedef struct packed {
    logic       on;
    midi_note_t note;
  } note_cand_t;

endpackage

// File: rtl/midi_event_sequencer_stabilizer.sv
// note_stabilizer: normalises the raw detector outputs into an
// {on, note} candidate (note forced to 0 when off), registers it, and
// counts how many consecutive cycles it has stayed unchanged.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   note_midi   - detected note number (don't-care when note_on=0)
//   note_on     - detector reports a note present
//   cand        - registered candidate {on, note}
//   stable      - candidate unchanged for HOLD_CYCLES cycles
module note_stabilizer
  import sqmidi_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 60_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] note_midi,
  input  logic       note_on,
  output note_cand_t cand,
  output logic       stable
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

  note_cand_t    cand_d;
  note_cand_t    cand_q;
  logic [CW-1:0] cnt;

  always_comb begin
    cand_d.on   = note_on;
    cand_d.note = note_on ? note_midi : 7'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q <= '0;
      cnt    <= '0;
    end else begin
      cand_q <= cand_d;
      if (cand_d != cand_q) begin
        cnt <= '0;
      end else if (cnt != HOLD_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    cand   = cand_q;
    stable = (cnt == HOLD_MAX);
  end

endmodule

// File: rtl/midi_event_sequencer.sv
// midi_event_sequencer: turns stable note-detector readings into
// 3-byte MIDI Note-Off / Note-On messages on a valid/ready byte stream.
// Optional build macro SQMIDI_RUNNING_STATUS_EN: repeated status bytes
// are suppressed and Note-Off is sent as Note-On with velocity 0.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   note_midi, note_on  - raw note detector outputs
//   out_byte, out_valid - byte to transmitter and its valid flag
//   out_ready           - transmitter accepts out_byte this cycle
//   busy                - a message is in progress (FSM not IDLE)
//   cur_note, cur_on    - currently sounding note (0 / 0 when none)
module midi_event_sequencer
  import sqmidi_pkg::*;
#(
  parameter int unsigned F_CLK    = 12_000_000,
  parameter int unsigned HOLD_MS  = 5,
  parameter int unsigned CHANNEL  = 0,
  parameter int unsigned VELOCITY = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] note_midi,
  input  logic       note_on,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [6:0] cur_note,
  output logic       cur_on
);

  localparam int unsigned HOLD_CYCLES =
    32'((64'(F_CLK) * 64'(HOLD_MS)) / 64'd1000);

  localparam logic [7:0] CH_BITS   = 8'(CHANNEL % 16);
  localparam logic [7:0] ON_STATUS = MIDI_NOTE_ON | CH_BITS;
  localparam logic [7:0] ON_VEL    = {1'b0, 7'(VELOCITY % 128)};
`ifdef SQMIDI_RUNNING_STATUS_EN
  localparam logic [7:0] OFF_STATUS = ON_STATUS;
  localparam logic [7:0] OFF_VEL    = 8'h00;
`else
  localparam logic [7:0] OFF_STATUS = MIDI_NOTE_OFF | CH_BITS;
  localparam logic [7:0] OFF_VEL    = {1'b0, MIDI_OFF_VEL};
`endif

  note_cand_t cand;
  logic       stable;

  note_stabilizer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stab (
    .clk      (clk),
    .reset    (reset),
    .note_midi(note_midi),
    .note_on  (note_on),
    .cand     (cand),
    .stable   (stable)
  );

  seq_state_t state, state_n;
  note_cand_t target, target_n;
  logic       cur_on_n;
  logic [6:0] cur_note_n;
  logic [7:0] out_byte_n;
  logic       out_valid_n;
  logic       xfer;
  logic       accept;

`ifdef SQMIDI_RUNNING_STATUS_EN
  logic       last_vld, last_vld_n;
  logic [7:0] last_st, last_st_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target    <= '0;
      cur_on    <= 1'b0;
      cur_note  <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
`ifdef SQMIDI_RUNNING_STATUS_EN
      last_vld  <= 1'b0;
      last_st   <= '0;
`endif
    end else begin
      state     <= state_n;
      target    <= target_n;
      cur_on    <= cur_on_n;
      cur_note  <= cur_note_n;
      out_byte  <= out_byte_n;
      out_valid <= out_valid_n;
`ifdef SQMIDI_RUNNING_STATUS_EN
      last_vld  <= last_vld_n;
      last_st   <= last_st_n;
`endif
    end
  end

  // out_byte/out_valid are loaded with the byte belonging to the state
  // being entered, so a transfer advances to the next byte with no bubble
  // and a stalled state simply reloads the same byte.
  always_comb begin
    state_n     = state;
    target_n    = target;
    cur_on_n    = cur_on;
    cur_note_n  = cur_note;
    out_byte_n  = out_byte;
    out_valid_n = 1'b0;
    xfer        = out_valid && out_ready;
    accept      = (state == IDLE) && stable && (cand != {cur_on, cur_note});
`ifdef SQMIDI_RUNNING_STATUS_EN
    last_vld_n  = last_vld;
    last_st_n   = last_st;
`endif

    case (state)
      IDLE: begin
        if (accept) begin
          target_n = cand;
          if (cur_on) begin
            state_n = OFF0;
          end else if (cand.on) begin
            state_n = ON0;
          end
        end
      end
      OFF0: if (xfer) state_n = OFF1;
      OFF1: if (xfer) state_n = OFF2;
      OFF2: begin
        if (xfer) begin
          cur_on_n   = 1'b0;
          cur_note_n = '0;
          state_n    = target.on ? ON0 : IDLE;
        end
      end
      ON0: if (xfer) state_n = ON1;
      ON1: if (xfer) state_n = ON2;
      ON2: begin
        if (xfer) begin
          cur_on_n   = 1'b1;
          cur_note_n = target.note;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef SQMIDI_RUNNING_STATUS_EN
    if (xfer && (state == OFF0 || state == ON0)) begin
      last_vld_n = 1'b1;
      last_st_n  = out_byte;
    end
    // Status byte skipped at entry, so byte 1 takes byte 0's slot.
    if (state_n != state && last_vld) begin
      if (state_n == OFF0 && last_st == OFF_STATUS) state_n = OFF1;
      if (state_n == ON0 && last_st == ON_STATUS) state_n = ON1;
    end
`endif

    case (state_n)
      OFF0: out_byte_n = OFF_STATUS;
      OFF1: out_byte_n = {1'b0, cur_note};
      OFF2: out_byte_n = OFF_VEL;
      ON0:  out_byte_n = ON_STATUS;
      ON1:  out_byte_n = {1'b0, target_n.note};
      ON2:  out_byte_n = ON_VEL;
      default: out_byte_n = out_byte;
    endcase
    out_valid_n = (state_n != IDLE);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_midi_event_sequencer.sv
// Scoreboard bench for midi_event_sequencer: stimulus pushes expected
// bytes, a negedge monitor pops and compares on every transfer.
module tb_midi_event_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] note_midi = 7'd0;
  logic       note_on = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic [6:0] cur_note;
  logic       cur_on;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  logic [7:0] exp_q[$];
  logic       have_last = 1'b0;
  logic [7:0] last_st = 8'h00;

  always #5 clk = ~clk;

  midi_event_sequencer #(
    .F_CLK   (16_000),
    .HOLD_MS (1),
    .CHANNEL (2),
    .VELOCITY(100)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .note_midi(note_midi),
    .note_on  (note_on),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .cur_note (cur_note),
    .cur_on   (cur_on)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: byte scoreboard, stall stability, busy while valid.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    logic [7:0] exp_b;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_byte", 32'(out_byte), 32'(prev_byte));
        end
        if (out_valid) check("busy_with_valid", 32'(busy), 32'd1);
        if (out_valid && out_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", out_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("byte", 32'(out_byte), 32'(exp_b));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
      end
    end
  end

  task automatic push_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
`ifdef SQMIDI_RUNNING_STATUS_EN
    if (!(have_last && last_st == st)) exp_q.push_back(st);
    have_last = 1'b1;
    last_st   = st;
`else
    exp_q.push_back(st);
`endif
    exp_q.push_back(d1);
    exp_q.push_back(d2);
  endtask

  task automatic push_on(input logic [6:0] n);
    push_msg(8'h92, {1'b0, n}, 8'h64);
  endtask

  task automatic push_off(input logic [6:0] n);
`ifdef SQMIDI_RUNNING_STATUS_EN
    push_msg(8'h92, {1'b0, n}, 8'h00);
`else
    push_msg(8'h82, {1'b0, n}, 8'h40);
`endif
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !out_valid) break;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cur_on", 32'(cur_on), 32'd0);
    exp_q.delete();
    have_last = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_out_byte", 32'(out_byte), 32'h00);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cur_on", 32'(cur_on), 32'd0);
    check("reset_cur_note", 32'(cur_note), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Silence -> 69
    note_on = 1'b1;
    note_midi = 7'd69;
    push_on(7'd69);
    wait_drain("on69");
    check("on69_cur_on", 32'(cur_on), 32'd1);
    check("on69_cur_note", 32'(cur_note), 32'd69);

    // 69 -> 76
    note_midi = 7'd76;
    push_off(7'd69);
    push_on(7'd76);
    wait_drain("chg76");
    check("chg76_cur_on", 32'(cur_on), 32'd1);
    check("chg76_cur_note", 32'(cur_note), 32'd76);

    // Bouncing shorter than the hold time produces nothing
    base = xfers;
    for (int k = 0; k < 12; k++) begin
      note_midi = (k % 2 == 1) ? 7'd70 : 7'd69;
      repeat (5) @(negedge clk);
    end
    note_midi = 7'd76;
    repeat (40) @(negedge clk);
    check("glitch_xfers", 32'(xfers - base), 32'd0);
    check("glitch_cur_note", 32'(cur_note), 32'd76);

    // 76 -> silence
    note_on = 1'b0;
    push_off(7'd76);
    wait_drain("off76");
    check("off76_cur_on", 32'(cur_on), 32'd0);
    check("off76_cur_note", 32'(cur_note), 32'd0);

    // Back-pressure: out_ready one cycle in three during a change
    note_on = 1'b1;
    note_midi = 7'd60;
    push_on(7'd60);
    wait_drain("on60");
    note_midi = 7'd62;
    push_off(7'd60);
    push_on(7'd62);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 out_ready = (i % 3 == 0);
      if (exp_q.size() == 0 && !busy && !out_valid) break;
    end
    out_ready = 1'b1;
    check("stall_left", 32'(exp_q.size()), 32'd0);
    check("stall_cur_note", 32'(cur_note), 32'd62);

    // Reset after the 2nd byte of a Note-On
    note_on = 1'b0;
    push_off(7'd62);
    wait_drain("off62");
    do_reset();
    note_on = 1'b1;
    note_midi = 7'd72;
    push_on(7'd72);
    base = xfers;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (xfers - base >= 2) break;
    end
    check("mid_two_bytes", 32'(xfers - base), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cur_on", 32'(cur_on), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cur_note", 32'(cur_note), 32'd0);
    exp_q.delete();
    have_last = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    push_on(7'd72);
    wait_drain("resend72");
    check("resend_cur_on", 32'(cur_on), 32'd1);
    check("resend_cur_note", 32'(cur_note), 32'd72);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_event_sequencer.md
Name: midi_event_sequencer

Overview:
- Sits between `which_note` and the byte-serial MIDI transmitter (UART TX).
- Filters the raw `midi`/`note_on` detector outputs for stability.
- Tracks the currently sounding note and schedules 3-byte MIDI Note-Off / Note-On messages over a valid/ready byte handshake.
- Owns the transmitter: it is the only source of bytes sent to it.

Parameters:
- F_CLK, 12_000_000, system clock frequency in Hz.
- HOLD_MS, 5, time in ms a detector reading must be unchanged before it is accepted. HOLD_CYCLES = F_CLK*HOLD_MS/1000, which is 60_000 at the defaults.
- CHANNEL, 0, MIDI channel 0..15, ORed into the status byte low nibble.
- VELOCITY, 100, Note-On velocity 1..127. Note-Off velocity is fixed at 0x40.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- note_midi  in  7  detected MIDI note number from the note detector.
- note_on  in  1  detector reports a note present; note_midi is don't-care when low.
- out_byte  out  8  MIDI byte to the transmitter.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  transmitter accepts out_byte this cycle.
- busy  out  1  FSM not in IDLE.
- cur_note  out  7  currently sounding note; 0 when none.
- cur_on  out  1  a note is currently sounding.

Behaviour:
- Reset values: out_byte=0, out_valid=0, busy=0, cur_note=0, cur_on=0, FSM=IDLE, stability counter=0, last-status=none.
- Normalisation: candidate = {note_on, note_on ? note_midi : 7'd0}.
  - The candidate is registered each cycle.
  - If the candidate differs from the previous registered value, the counter clears to 0. Otherwise it increments, saturating at HOLD_CYCLES.
  - Counter width is $clog2(HOLD_CYCLES+1).
- Acceptance: in IDLE, when counter==HOLD_CYCLES and candidate != {cur_on,cur_note}, the change is accepted that cycle. While the FSM is not IDLE, the counter keeps running but nothing is accepted. A change that remains stable is accepted on the first IDLE cycle.
- FSM states: IDLE, OFF0, OFF1, OFF2, ON0, ON1, ON2. The state register holds the target note latched at acceptance.
  - On acceptance, if cur_on=1, go to OFF0. Otherwise, if the target is on, go to ON0.
  - OFF0/1/2 emit 0x80|CHANNEL, cur_note, 0x40.
  - ON0/1/2 emit 0x90|CHANNEL, target note, VELOCITY.
  - After OFF2 completes: cur_on=0, cur_note=0. Then go to ON0 if the target is on, else IDLE.
  - After ON2 completes: cur_on=1, cur_note=target, then IDLE.
- Handshake:
  - out_valid is registered; it rises the cycle after acceptance or state entry.
  - out_byte must be stable while out_valid=1 and out_ready=0.
  - A byte transfers on a cycle with out_valid && out_ready. The next byte appears the following cycle, with no bubble: sustained out_ready=1 gives 1 byte/clock.
  - out_valid never drops without a transfer, except on reset.
- Note change A→B takes 6 bytes (Off A then On B). On→silence takes 3 bytes; silence→note takes 3 bytes.
- Detector bouncing shorter than HOLD_CYCLES produces no traffic.
- Reset mid-message: immediate return to reset values. No Note-Off is generated for a note that was sounding; the downstream consumer must handle this.
- out_ready asserted while out_valid=0 is ignored.

Optional Feature:
- Macro: SQMIDI_RUNNING_STATUS_EN.
- Defined:
  - Track the last transmitted status byte; cleared to none on reset.
  - In OFF0/ON0, if the status equals last-status, skip the status byte and go directly to OFF1/ON1 in the same cycle as entry would occur. Byte 1 then appears where byte 0 would have.
  - A Note-Off is sent as Note-On with velocity 0 (status 0x90|CHANNEL, data cur_note, 0x00). This maximises running-status reuse.
- Not defined: every message carries its status byte, and Note-Off uses 0x80 as described above.

Decomposition:
- Package sqmidi_pkg:
  - typedef midi_note_t (logic[6:0]).
  - constants MIDI_NOTE_OFF=8'h80, MIDI_NOTE_ON=8'h90, MIDI_OFF_VEL=7'h40.
  - seq_state_t enum for the FSM states.
- Sub-module note_stabilizer (params HOLD_CYCLES): inputs note_midi/note_on; outputs stable candidate and a `stable` flag. It covers normalisation, registering and the saturating counter.
- The FSM and handshake stay in midi_event_sequencer.

Test Plan (HOLD_MS overridden to give HOLD_CYCLES=16, CHANNEL=2, VELOCITY=100, out_ready=1 unless stated):
- note_on=1, note_midi=69 held → after 16 stable cycles, bytes 0x92,0x45,0x64 on 3 consecutive cycles; cur_on=1, cur_note=69.
- From note 69, switch to 76 and hold → 0x82,0x45,0x40 then 0x92,0x4C,0x64; cur_note=76.
- From 76, note_on=0 held → 0x82,0x4C,0x40; cur_on=0, cur_note=0. Glitching note_midi 69↔70 every 5 cycles produces no bytes.
- out_ready toggled 1-in-3 during a change → out_byte stable while stalled, same 6-byte sequence, busy high throughout.
- Assert reset after the 2nd byte of a Note-On → next cycle out_valid=0, cur_on=0, busy=0; after release with the input held, the full 3-byte message is resent.
- SQMIDI_RUNNING_STATUS_EN: sequence 69→76→off → 0x92,0x45,0x64, 0x45,0x00, 0x4C,0x64, 0x4C,0x00.
